// File: rtl/conv_output_stage_pkg.sv
// Shared definitions for the convolution output stage.
// Holds default widths, the serializer state encoding, a safe index-width
// helper and the round/ReLU/saturate helper used on each filter result.
package conv_output_stage_pkg;

  localparam int ACC_WIDTH_DEF   = 33;
  localparam int DATA_WIDTH_DEF  = 16;
  localparam int POF_DEF         = 4;
  localparam int FIFO_DEPTH_DEF  = 16;
  localparam int SHIFT_WIDTH_DEF = 5;

  typedef enum logic {
    SER_IDLE = 1'b0,
    SER_SEND = 1'b1
  } ser_state_e;

  // Width of an index over n items, never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int FIDX_W_DEF = idx_width(POF_DEF);

  // Round-half-up arithmetic right shift, optional ReLU, then saturation to
  // a signed dw-bit range. Operands are carried at 64 bits, which is wider
  // than any accumulator sum plus rounding constant, so every step is exact.
  function automatic logic signed [63:0] round_relu_sat(
    input logic signed [63:0] sum,
    input int                 shamt,
    input logic               relu,
    input int                 dw
  );
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r = sum;
    if (shamt > 0) begin
      r = (sum + (64'sd1 <<< (shamt - 1))) >>> shamt;
    end
    if (relu && (r < 0)) begin
      r = '0;
    end
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/conv_output_stage_if.sv
// Output stream of the convolution output stage: one filter sample per beat.
// Handshake: a beat transfers on a rising clk edge where out_valid and
// out_ready are both 1. While out_valid=1 and out_ready=0 the source holds
// out_data, out_fidx and out_last stable and does not drop out_valid.
// out_ready may change freely and does not depend on out_valid.
// Signals:
//   out_valid  source -> sink  beat valid
//   out_ready  sink -> source  beat accepted
//   out_data   source -> sink  signed sample
//   out_fidx   source -> sink  filter index of the beat
//   out_last   source -> sink  final filter of the vector
interface conv_output_stage_if #(
  parameter int DATA_WIDTH = 16,
  parameter int FIDX_W     = 2
);
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic [FIDX_W-1:0]            out_fidx;
  logic                         out_last;

  modport master (
    output out_valid, out_data, out_fidx, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_fidx, out_last,
    output out_ready
  );
endinterface

// File: rtl/conv_output_stage_sync_fifo.sv
// Synchronous FIFO with show-ahead read data, usable by any stream stage.
// Ports:
//   clk, rst   clock, synchronous active-high reset (pointers and count)
//   push_i     write din_i; ignored when full unless pop_i is also high
//   din_i      write data
//   pop_i      remove the head entry; ignored when empty
//   dout_o     current head entry
//   full_o     DEPTH entries held
//   empty_o    no entries held
//   count_o    entries held, 0..DEPTH
module conv_output_stage_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO still succeeds when the head leaves this cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/conv_output_stage.sv
// Convolution output stage: per-filter bias add, rounding shift, optional
// ReLU and saturation of a POF-wide accumulator vector, buffered in a FIFO
// and serialised one filter per beat.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   res_valid    single-cycle strobe for res_flat, no backpressure
//   res_flat     POF accumulators, filter f at [f*ACC_WIDTH +: ACC_WIDTH]
//   bias_we      bias write strobe; bias_addr >= POF is ignored
//   bias_addr    filter index to write
//   bias_in      signed bias value
//   shift_amt    rounding right shift, changed only while idle
//   relu_en      clamp negative results to zero
//   clear_ovf    clear the sticky overflow flag
//   out_if       output sample stream (master side)
//   overflow     sticky: a vector was dropped on a full FIFO
//   fifo_count   vectors waiting in the FIFO
//   dbg_state_o  serializer state
module conv_output_stage
  import conv_output_stage_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
  parameter int POF         = POF_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int SHIFT_WIDTH = SHIFT_WIDTH_DEF,
  localparam int FIDX_W     = idx_width(POF),
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         res_valid,
  input  logic [POF*ACC_WIDTH-1:0]     res_flat,
  input  logic                         bias_we,
  input  logic [FIDX_W-1:0]            bias_addr,
  input  logic signed [DATA_WIDTH-1:0] bias_in,
  input  logic [SHIFT_WIDTH-1:0]       shift_amt,
  input  logic                         relu_en,
  input  logic                         clear_ovf,
  conv_output_stage_if.master          out_if,
  output logic                         overflow,
  output logic [CNT_W-1:0]             fifo_count,
  output ser_state_e                   dbg_state_o
);

  localparam int SUM_W = ACC_WIDTH + 1;
  localparam int VEC_W = POF * DATA_WIDTH;

  // Bias registers
  logic signed [DATA_WIDTH-1:0] bias_q [POF];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int f = 0; f < POF; f++) begin
        bias_q[f] <= '0;
      end
    end else if (bias_we && (int'(bias_addr) < POF)) begin
      bias_q[bias_addr] <= bias_in;
    end
  end

  // Stage 1: exact bias add, one bit wider than the accumulator
  logic signed [ACC_WIDTH-1:0] res_f  [POF];
  logic signed [SUM_W-1:0]     sum1_d [POF];
  logic signed [SUM_W-1:0]     sum1_q [POF];
  logic                        v1_q;

  always_comb begin
    for (int f = 0; f < POF; f++) begin
      res_f[f]  = res_flat[f*ACC_WIDTH +: ACC_WIDTH];
      sum1_d[f] = SUM_W'(res_f[f]) + SUM_W'(bias_q[f]);
    end
  end

  // Stage 2: round, ReLU, saturate
  logic [VEC_W-1:0] res2_d;
  logic [VEC_W-1:0] res2_q;
  logic             v2_q;

  always_comb begin
    res2_d = '0;
    for (int f = 0; f < POF; f++) begin
      res2_d[f*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(round_relu_sat(
        64'(sum1_q[f]), int'(shift_amt), relu_en, DATA_WIDTH));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      res2_q <= '0;
      for (int f = 0; f < POF; f++) begin
        sum1_q[f] <= '0;
      end
    end else begin
      v1_q   <= res_valid;
      v2_q   <= v1_q;
      res2_q <= res2_d;
      for (int f = 0; f < POF; f++) begin
        sum1_q[f] <= sum1_d[f];
      end
    end
  end

  // Result FIFO
  logic             ser_pop;
  logic [VEC_W-1:0] fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic             drop;

  conv_output_stage_sync_fifo #(
    .WIDTH (VEC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (v2_q),
    .din_i   (res2_q),
    .pop_i   (ser_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign drop = v2_q && fifo_full && !ser_pop;

  logic overflow_q;
  logic overflow_d;

  // A drop in the same cycle as a clear leaves the flag set.
  always_comb begin
    overflow_d = overflow_q;
    if (clear_ovf) begin
      overflow_d = 1'b0;
    end
    if (drop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;

  // Serializer
  ser_state_e                   state_q, state_d;
  logic [FIDX_W-1:0]            fidx_q, fidx_d;
  logic [VEC_W-1:0]             hold_q, hold_d;
  logic                         out_valid_q, out_valid_d;
  logic signed [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [FIDX_W-1:0]            out_fidx_q, out_fidx_d;
  logic                         out_last_q, out_last_d;
  logic                         accept;

  assign accept = out_valid_q && out_if.out_ready;

  always_comb begin
    state_d = state_q;
    fidx_d  = fidx_q;
    hold_d  = hold_q;
    ser_pop = 1'b0;
    case (state_q)
      SER_IDLE: begin
        if (!fifo_empty) begin
          ser_pop = 1'b1;
          hold_d  = fifo_dout;
          fidx_d  = '0;
          state_d = SER_SEND;
        end
      end
      SER_SEND: begin
        if (accept) begin
          if (fidx_q == FIDX_W'(POF - 1)) begin
            // Reload straight from the FIFO so vectors stream without a gap.
            if (!fifo_empty) begin
              ser_pop = 1'b1;
              hold_d  = fifo_dout;
              fidx_d  = '0;
            end else begin
              state_d = SER_IDLE;
            end
          end else begin
            fidx_d = fidx_q + FIDX_W'(1);
          end
        end
      end
      default: state_d = SER_IDLE;
    endcase
    // Output registers are loaded from the next state so they line up with it.
    out_valid_d = (state_d == SER_SEND);
    out_data_d  = hold_d[int'(fidx_d)*DATA_WIDTH +: DATA_WIDTH];
    out_fidx_d  = fidx_d;
    out_last_d  = (fidx_d == FIDX_W'(POF - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SER_IDLE;
      fidx_q      <= '0;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_fidx_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fidx_q      <= fidx_d;
      hold_q      <= hold_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_fidx_q  <= out_fidx_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_if.out_valid = out_valid_q;
  assign out_if.out_data  = out_data_q;
  assign out_if.out_fidx  = out_fidx_q;
  assign out_if.out_last  = out_last_q;
  assign dbg_state_o      = state_q;

endmodule
